// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared types, sizes and line-selection helpers for the
//                event encoder front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef logic [N_LINES-1:0] line_vec_t;
    typedef logic [CODE_W-1:0]  code_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Highest set index wins; returns 0 for an empty vector (caller gates on |vec).
    function automatic code_t sel_fixed(input line_vec_t vec);
        code_t sel;
        sel = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (vec[i]) begin
                sel = code_t'(i);
            end
        end
        return sel;
    endfunction

    // First set bit searching upward from ptr, wrapping from the top line to line 0.
    function automatic code_t sel_rr(input line_vec_t vec, input code_t ptr);
        code_t sel;
        code_t idx;
        logic  found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            idx = ptr + code_t'(i);
            if (!found && vec[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // One-hot mask for a line number.
    function automatic line_vec_t onehot(input code_t k);
        return line_vec_t'(1) << k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_rise_detect
//  Description : Multi-flop synchroniser for one asynchronous line followed
//                by a history flop; flags a single-cycle rising edge.
//                SYNC_STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw line through the synchroniser and remember the last synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History clears in reset, so a line held high through reset yields one event.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/event_encoder_8x3.sv
`default_nettype none
// ============================================================================
//  Module      : event_encoder_8x3
//  Description : Synchronises eight asynchronous event lines, captures rising
//                edges as pending events and presents them one at a time as
//                a 3-bit line code on a valid/ready handshake. Round-robin or
//                fixed (highest index) selection; drops are flagged on lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_encoder_8x3
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RR          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    output logic [2:0] a,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       lost
);

    line_vec_t rise;
    line_vec_t pending_q;
    line_vec_t pending_d;
    line_vec_t clr_mask;
    code_t     ptr_q;
    code_t     ptr_d;
    code_t     a_q;
    code_t     sel;
    state_t    state_q;
    state_t    state_d;
    logic      valid_q;
    logic      lost_q;
    logic      lost_d;
    logic      load;

    // One synchroniser/edge detector per event line.
    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        sync_rise_detect #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (d[i]),
            .rise (rise[i])
        );
    end

    // Selection, load decision and pending/lost next-state; a same-cycle set beats the load-clear.
    always_comb begin
        sel       = (RR != 0) ? sel_rr(pending_q, ptr_q) : sel_fixed(pending_q);
        load      = (|pending_q) && ((state_q == IDLE) || ready);
        clr_mask  = load ? onehot(sel) : '0;
        pending_d = (pending_q & ~clr_mask) | rise;
        lost_d    = |(rise & pending_q & ~clr_mask);
        ptr_d     = ptr_q;
        state_d   = state_q;
        if (load) begin
            state_d = HOLD;
            if (RR != 0) begin
                ptr_d = sel + code_t'(1);
            end
        end else if ((state_q == HOLD) && ready) begin
            state_d = IDLE;
        end
    end

    // Output FSM with registered code, valid, pending and loss pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            a_q       <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            valid_q   <= (state_d == HOLD);
            lost_q    <= lost_d;
            if (load) begin
                a_q <= sel;
            end
        end
    end

    assign a       = a_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign lost    = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_8x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_encoder_8x3
//  Description : Scoreboard bench for event_encoder_8x3; a round-robin
//                instance carries most scenarios, a fixed-priority instance
//                checks simultaneous-event ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder_8x3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d     = 8'h00;
    logic [7:0] d_fp  = 8'h00;
    logic       ready = 1'b1;

    logic [2:0] a;
    logic       valid;
    logic [7:0] pending;
    logic       lost;
    logic [2:0] a_fp;
    logic       valid_fp;
    logic [7:0] pending_fp;
    logic       lost_fp;

    int errors   = 0;
    int checks   = 0;
    int lost_cnt = 0;
    int lost_base;

    logic [2:0] q_rr[$];
    logic [2:0] q_fp[$];
    logic [2:0] exp_rr;
    logic [2:0] exp_fp;

    event_encoder_8x3 #(.SYNC_STAGES(2), .RR(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .a      (a),
        .valid  (valid),
        .ready  (ready),
        .pending(pending),
        .lost   (lost)
    );

    event_encoder_8x3 #(.SYNC_STAGES(2), .RR(0)) dut_fp (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d_fp),
        .a      (a_fp),
        .valid  (valid_fp),
        .ready  (1'b1),
        .pending(pending_fp),
        .lost   (lost_fp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] m);
        @(negedge clk);
        d = d | m;
        repeat (2) @(negedge clk);
        d = d & ~m;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
    endtask

    // Round-robin scoreboard: every handshake pops one expected code.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (q_rr.size() == 0) begin
                errors++;
                $display("FAIL rr_unexpected: got a=%0d expected no handshake", a);
            end else begin
                exp_rr = q_rr.pop_front();
                if (a !== exp_rr) begin
                    errors++;
                    $display("FAIL rr_code: got a=%0d expected a=%0d", a, exp_rr);
                end
            end
        end
    end

    // Fixed-priority scoreboard (ready tied high).
    always @(negedge clk) begin
        if (rst_n && valid_fp) begin
            checks++;
            if (q_fp.size() == 0) begin
                errors++;
                $display("FAIL fp_unexpected: got a=%0d expected no handshake", a_fp);
            end else begin
                exp_fp = q_fp.pop_front();
                if (a_fp !== exp_fp) begin
                    errors++;
                    $display("FAIL fp_code: got a=%0d expected a=%0d", a_fp, exp_fp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && lost) lost_cnt++;
    end

    initial begin
        // Reset state
        cyc(3);
        check("rst_a", a, 0);
        check("rst_valid", valid, 0);
        check("rst_pending", pending, 0);
        check("rst_lost", lost, 0);
        check("rst_valid_fp", valid_fp, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(2);

        // Single event on line 3: valid three edges after the sampling edge
        q_rr.push_back(3'd3);
        d = 8'h08;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) d = 8'h00;
            if (k <= 3) check("single_latency_valid", valid, 0);
            if (k == 3) check("single_pending", pending, 8'h08);
            if (k == 4) begin
                check("single_valid", valid, 1);
                check("single_a", a, 3);
                check("single_pending_clr", pending, 0);
            end
            if (k == 5) check("single_one_cycle", valid, 0);
        end

        // Simultaneous 8'h12: RR from ptr 0 gives 1 then 4, fixed gives 4 then 1
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1);
        q_rr.push_back(3'd1);
        q_rr.push_back(3'd4);
        q_fp.push_back(3'd4);
        q_fp.push_back(3'd1);
        d    = 8'h12;
        d_fp = 8'h12;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                d    = 8'h00;
                d_fp = 8'h00;
            end
            if (k == 3) check("simul_pending", pending, 8'h12);
            if (k == 4) check("simul_first_a", a, 1);
            if (k == 5) begin
                check("simul_no_bubble", valid, 1);
                check("simul_second_a", a, 4);
                check("simul_fp_second_a", a_fp, 1);
            end
            if (k == 6) check("simul_idle", valid, 0);
        end

        // Backpressure and loss on line 1
        set_ready(1'b0);
        pulse(8'h02);
        cyc(4);
        check("bp_valid", valid, 1);
        check("bp_a", a, 1);
        check("bp_pending_empty", pending, 0);
        lost_base = lost_cnt;
        pulse(8'h02);
        cyc(4);
        check("bp_second_pending", pending, 8'h02);
        check("bp_second_no_lost", lost_cnt, lost_base);
        pulse(8'h02);
        cyc(4);
        check("bp_third_lost_once", lost_cnt, lost_base + 1);
        check("bp_third_pending", pending, 8'h02);
        check("bp_a_held", a, 1);
        q_rr.push_back(3'd1);
        q_rr.push_back(3'd1);
        set_ready(1'b1);
        cyc(4);
        check("bp_drained_valid", valid, 0);
        check("bp_drained_pending", pending, 0);

        // Round-robin with lines 7 and 0 together; ptr wraps from 7 to 0 each round
        lost_base = lost_cnt;
        for (int r = 0; r < 3; r++) begin
            q_rr.push_back(3'd7);
            q_rr.push_back(3'd0);
            pulse(8'h81);
            cyc(4);
            check("rr_round_idle", valid, 0);
        end
        check("rr_no_lost", lost_cnt, lost_base);

        // Set/clear collision on line 2
        set_ready(1'b0);
        q_rr.push_back(3'd2);
        q_rr.push_back(3'd2);
        q_rr.push_back(3'd2);
        pulse(8'h04);
        cyc(4);
        check("coll_present_a", a, 2);
        check("coll_present_valid", valid, 1);
        pulse(8'h04);
        cyc(4);
        check("coll_pending_before", pending, 8'h04);
        lost_base = lost_cnt;
        @(negedge clk);
        d = 8'h04;
        @(posedge clk);
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        d = 8'h00;
        @(negedge clk);
        check("coll_pending_kept", pending, 8'h04);
        check("coll_no_lost", lost, 0);
        check("coll_reload_a", a, 2);
        cyc(4);
        check("coll_drained", valid, 0);
        check("coll_lost_total", lost_cnt, lost_base);

        // Asynchronous reset mid-transfer
        set_ready(1'b0);
        pulse(8'h01);
        cyc(4);
        check("mrst_setup_a", a, 0);
        check("mrst_setup_valid", valid, 1);
        pulse(8'hA0);
        cyc(4);
        check("mrst_setup_pending", pending, 8'hA0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", valid, 0);
        check("mrst_pending", pending, 0);
        check("mrst_a", a, 0);
        check("mrst_lost", lost, 0);
        @(posedge clk);
        #1 begin
            rst_n = 1'b1;
            ready = 1'b1;
        end
        cyc(12);
        check("mrst_quiet", valid, 0);

        check("rr_queue_empty", q_rr.size(), 0);
        check("fp_queue_empty", q_fp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
